// File: rtl/target_pkg.sv
// Shared types, geometry and default tuning for the enemy target.
// Also holds the lane-to-y helper used by the spawn path.
package target_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned LANE_W = 3;
  localparam int unsigned ANIM_W = 2;

  localparam int unsigned X_SPAWN_DEF = 639;
  localparam int unsigned X_STEP_DEF  = 3;
  localparam int unsigned Y_BASE_DEF  = 32;
  localparam int unsigned Y_LANE_DEF  = 56;
  localparam int unsigned FRAME_T_DEF = 8;

  typedef enum logic [1:0] {
    TARGET_IDLE    = 2'b00,
    TARGET_ALIVE   = 2'b01,
    TARGET_DYING   = 2'b10,
    TARGET_ILLEGAL = 2'b11
  } target_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } target_pos_t;

  // base + lane*pitch, expanded into one shifted add per set bit of the constant pitch
  function automatic logic [Y_W-1:0] lane_y(input logic [LANE_W-1:0] lane,
                                            input int unsigned base,
                                            input int unsigned pitch);
    logic [Y_W-1:0] acc;
    acc = Y_W'(base);
    for (int i = 0; i < int'(Y_W); i++) begin
      if (pitch[i]) acc = acc + (Y_W'(lane) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/target_anim_ticker.sv
// Frame timer plus 2-bit sprite frame counter; wrap_c pulses on the last tick of a frame.
// Used for both the wing flap and the death sequence.
module anim_ticker
  import target_pkg::*;
#(
  parameter int unsigned FRAME_T = FRAME_T_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  output logic [ANIM_W-1:0] frame,
  output logic              wrap_c
);

  localparam int unsigned T_W = (FRAME_T > 1) ? $clog2(FRAME_T) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(FRAME_T - 1);

  logic [T_W-1:0] timer;

  assign wrap_c = enable && (timer == T_LAST);

  // clear wins over counting so a state change always restarts at frame 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      frame <= '0;
    end else if (clear) begin
      timer <= '0;
      frame <= '0;
    end else if (enable) begin
      if (wrap_c) begin
        timer <= '0;
        frame <= frame + ANIM_W'(1);
      end else begin
        timer <= timer + T_W'(1);
      end
    end
  end

endmodule

// File: rtl/target.sv
// Single enemy target: spawns in a lane, flies left each tick, plays a
// four-frame death animation when shot, then returns to idle.
module target
  import target_pkg::*;
#(
  parameter int unsigned X_SPAWN = X_SPAWN_DEF,
  parameter int unsigned X_STEP  = X_STEP_DEF,
  parameter int unsigned Y_BASE  = Y_BASE_DEF,
  parameter int unsigned Y_LANE  = Y_LANE_DEF,
  parameter int unsigned FRAME_T = FRAME_T_DEF
) (
  input  logic              clk_100Hz,
  input  logic              rst,
  input  logic              start,
  input  logic [LANE_W-1:0] din,
  input  logic              shot,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [1:0]        state,
  output logic [ANIM_W-1:0] animation_state
);

  localparam logic [ANIM_W-1:0] LAST_FRAME = ANIM_W'(3);

  target_state_e state_q, state_d;
  target_pos_t   pos_q, pos_d;

  logic              anim_clear_c;
  logic              anim_en_c;
  logic              anim_wrap_c;
  logic [ANIM_W-1:0] anim_frame;

  anim_ticker #(
    .FRAME_T (FRAME_T)
  ) u_anim (
    .clk    (clk_100Hz),
    .rst_n  (rst),
    .clear  (anim_clear_c),
    .enable (anim_en_c),
    .frame  (anim_frame),
    .wrap_c (anim_wrap_c)
  );

  always_ff @(posedge clk_100Hz or negedge rst) begin
    if (!rst) begin
      state_q <= TARGET_IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // Next state and position; shot beats exit beats move while alive
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    anim_clear_c = 1'b0;
    anim_en_c    = 1'b0;
    case (state_q)
      TARGET_IDLE: begin
        if (start) begin
          state_d      = TARGET_ALIVE;
          pos_d.x      = X_W'(X_SPAWN);
          pos_d.y      = lane_y(din, Y_BASE, Y_LANE);
          anim_clear_c = 1'b1;
        end
      end
      TARGET_ALIVE: begin
        if (shot) begin
          state_d      = TARGET_DYING;
          anim_clear_c = 1'b1;
        end else begin
          anim_en_c = 1'b1;
          if (pos_q.x < X_W'(X_STEP)) begin
            state_d = TARGET_IDLE;
          end else begin
            pos_d.x = pos_q.x - X_W'(X_STEP);
          end
        end
      end
      TARGET_DYING: begin
        anim_en_c = 1'b1;
        if (anim_wrap_c && (anim_frame == LAST_FRAME)) begin
          state_d      = TARGET_IDLE;
          anim_clear_c = 1'b1;
        end
      end
      default: begin
        state_d = TARGET_IDLE;
      end
    endcase
  end

  assign x               = pos_q.x;
  assign y               = pos_q.y;
  assign state           = state_q;
  assign animation_state = anim_frame;

endmodule

// File: tb/tb_target.sv
// Directed bench for target: reset, spawn, exit, kill sequence, ignored inputs
// and same-edge priority cases, with hand-computed expectations.
module tb_target;

  logic       clk_100Hz;
  logic       rst;
  logic       start;
  logic [2:0] din;
  logic       shot;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] state;
  logic [1:0] animation_state;

  int checks = 0;
  int errors = 0;

  target dut (
    .clk_100Hz       (clk_100Hz),
    .rst             (rst),
    .start           (start),
    .din             (din),
    .shot            (shot),
    .x               (x),
    .y               (y),
    .state           (state),
    .animation_state (animation_state)
  );

  initial clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  task automatic tick();
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int s, input int ex, input int ey, input int ea);
    check({tag, ".state"}, 16'(state), 16'(s));
    check({tag, ".x"}, 16'(x), 16'(ex));
    check({tag, ".y"}, 16'(y), 16'(ey));
    check({tag, ".anim"}, 16'(animation_state), 16'(ea));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    din   = 3'd0;
    shot  = 1'b0;
    ticks(3);
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    check_all("idle_after_reset", 0, 0, 0, 0);

    // shot while idle does nothing
    shot = 1'b1;
    ticks(2);
    check_all("idle_shot", 0, 0, 0, 0);
    shot = 1'b0;

    // spawn in lane 3
    start = 1'b1;
    din   = 3'd3;
    tick();
    check_all("spawn3", 1, 639, 200, 0);
    start = 1'b0;
    din   = 3'd0;
    ticks(10);
    check_all("move10", 1, 609, 200, 1);

    // start toggling while alive: no respawn, lane unchanged
    din = 3'd7;
    for (int k = 0; k < 203; k++) begin
      start = k[0];
      tick();
    end
    start = 1'b0;
    check("exit_edge.x", 16'(x), 16'd0);
    check("exit_edge.state", 16'(state), 16'd1);
    check("exit_edge.y", 16'(y), 16'd200);
    tick();
    check("exited.state", 16'(state), 16'd0);
    check("exited.x", 16'(x), 16'd0);
    check("exited.y", 16'(y), 16'd200);

    // spawn lane 5, shoot after 50 moves
    start = 1'b1;
    din   = 3'd5;
    tick();
    check_all("spawn5", 1, 639, 312, 0);
    start = 1'b0;
    ticks(50);
    check("pre_shot.x", 16'(x), 16'd489);
    shot = 1'b1;
    tick();
    check_all("shot", 2, 489, 312, 0);

    // death sequence with start/shot toggling: 8 ticks per frame, idle at 32
    for (int k = 1; k <= 32; k++) begin
      start = k[0];
      shot  = ~k[0];
      tick();
      if (k < 32) begin
        check($sformatf("dying%0d.state", k), 16'(state), 16'd2);
        check($sformatf("dying%0d.anim", k), 16'(animation_state), 16'(k / 8));
        check($sformatf("dying%0d.x", k), 16'(x), 16'd489);
      end
    end
    check_all("death_done", 0, 489, 312, 0);
    start = 1'b0;
    shot  = 1'b0;
    tick();
    check("post_death_idle.state", 16'(state), 16'd0);

    // start and shot together in idle: spawn wins
    start = 1'b1;
    shot  = 1'b1;
    din   = 3'd0;
    tick();
    check_all("start_shot_idle", 1, 639, 32, 0);
    start = 1'b0;
    shot  = 1'b0;
    ticks(213);
    check("at_zero.x", 16'(x), 16'd0);
    check("at_zero.state", 16'(state), 16'd1);

    // shot on the exit tick: shot wins
    shot = 1'b1;
    tick();
    check_all("shot_on_exit", 2, 0, 32, 0);
    shot = 1'b0;
    ticks(31);
    check("exit_dying31.state", 16'(state), 16'd2);
    check("exit_dying31.anim", 16'(animation_state), 16'd3);
    tick();
    check_all("exit_dying_done", 0, 0, 32, 0);

    // lane 7 spawn then async reset mid-flight
    start = 1'b1;
    din   = 3'd7;
    tick();
    check_all("spawn7", 1, 639, 424, 0);
    start = 1'b0;
    ticks(5);
    rst = 1'b0;
    #1;
    check_all("reset_flight", 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    tick();

    // async reset mid-death
    start = 1'b1;
    din   = 3'd2;
    tick();
    check("spawn2.y", 16'(y), 16'd144);
    start = 1'b0;
    shot  = 1'b1;
    tick();
    shot = 1'b0;
    ticks(10);
    check("mid_death.state", 16'(state), 16'd2);
    check("mid_death.anim", 16'(animation_state), 16'd1);
    rst = 1'b0;
    #1;
    check_all("reset_death", 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    tick();
    check("after_reset.state", 16'(state), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
